// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the MIPS execute-stage multiply/divide
//                unit: operation encodings, FSM state type, iteration count
//                and small op-decoding helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Operation encodings on the op port. Bit 1 selects divide, bit 0 selects
    // signed arithmetic.
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    // One result bit per iteration.
    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic op_is_div(input logic [1:0] code);
        return code[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] code);
        return code[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/flopenr.sv
`default_nettype none
// ============================================================================
//  Module      : flopenr
//  Description : Resettable, enabled register.
//  Revision    : 1.0  initial release
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous active-high reset, clears q
//                en    - load enable
//                d     - data in
//                q     - registered data out
// ============================================================================
module flopenr #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multdiv_md_step.sv
`default_nettype none
// ============================================================================
//  Module      : md_step
//  Description : One combinational iteration of the multiply/divide datapath.
//                Multiply: shift-right-add on the {acc, shreg} pair, shreg
//                holding the multiplier and opnd the multiplicand.
//                Divide: restoring step on {acc, shreg} = {rem, quot}, opnd
//                holding the divisor.
//  Revision    : 1.0  initial release
//  Ports       : acc        - upper half (partial product / remainder)
//                shreg      - lower half (multiplier / dividend->quotient)
//                opnd       - multiplicand or divisor magnitude
//                is_div     - 1 selects the divide step
//                acc_next   - next upper half
//                shreg_next - next lower half
// ============================================================================
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] shreg,
    input  logic [WIDTH-1:0] opnd,
    input  logic             is_div,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] shreg_next
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;

    always_comb begin
        // Multiply: conditional add with a carry bit, then shift the 65-bit
        // {carry, acc, shreg} right by one.
        w_sum = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

        // Divide: the shifted remainder needs WIDTH+1 bits, since the
        // remainder before the shift can be as large as the divisor minus one
        // (or any value when the divisor is zero).
        w_rem    = {acc, shreg[WIDTH-1]};
        w_borrow = (w_rem < {1'b0, opnd});
        w_diff   = w_rem[WIDTH-1:0] - opnd;

        if (is_div) begin
            acc_next   = w_borrow ? w_rem[WIDTH-1:0] : w_diff;
            shreg_next = {shreg[WIDTH-2:0], ~w_borrow};
        end else begin
            acc_next   = w_sum[WIDTH:1];
            shreg_next = {w_sum[0], shreg[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/multdiv.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv
//  Description : Iterative 32-bit multiply/divide unit producing HI/LO for
//                MULTU, MULT, DIVU and DIV. One iteration per cycle; fixed
//                34-cycle latency from the accepting edge to done.
//  Revision    : 1.0  initial release
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous active-high reset
//                start - request, sampled only while busy=0
//                op    - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//                a     - multiplicand / dividend
//                b     - multiplier / divisor
//                busy  - operation in progress
//                done  - one-cycle pulse when hi/lo were updated
//                hi    - upper product / remainder
//                lo    - lower product / quotient
// ============================================================================
module multdiv
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_opnd;
    logic             r_is_div;
    logic             r_is_signed;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_acc_step;
    logic [WIDTH-1:0] w_shreg_step;
    logic [WIDTH-1:0] w_acc_fix;
    logic [WIDTH-1:0] w_shreg_fix;
    logic             w_hilo_en;

    // Operand magnitudes; unsigned ops pass straight through. The most
    // negative value maps onto itself, which is its correct unsigned magnitude.
    always_comb begin
        w_a_mag = (op_is_signed(op) && a[WIDTH-1]) ? -a : a;
        w_b_mag = (op_is_signed(op) && b[WIDTH-1]) ? -b : b;
    end

    md_step #(
        .WIDTH      (WIDTH)
    ) u_md_step (
        .acc        (r_acc),
        .shreg      (r_shreg),
        .opnd       (r_opnd),
        .is_div     (r_is_div),
        .acc_next   (w_acc_step),
        .shreg_next (w_shreg_step)
    );

    // Sign correction of the unsigned result for signed ops.
    always_comb begin
        w_acc_fix   = r_acc;
        w_shreg_fix = r_shreg;
        if (r_is_signed) begin
            if (r_is_div) begin
                if (r_sign_a ^ r_sign_b) begin
                    w_shreg_fix = -r_shreg;
                end
                if (r_sign_a) begin
                    w_acc_fix = -r_acc;
                end
            end else if (r_sign_a ^ r_sign_b) begin
                {w_acc_fix, w_shreg_fix} = -{r_acc, r_shreg};
            end
        end
    end

    // FIX spans two cycles: the counter (zero on entry after wrapping) marks
    // the first cycle, which applies the sign correction in place; the
    // second cycle loads hi/lo and raises done.
    always_comb begin
        w_hilo_en = (r_state == FIX) && (r_cnt != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_shreg     <= '0;
            r_opnd      <= '0;
            r_is_div    <= 1'b0;
            r_is_signed <= 1'b0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shreg     <= w_a_mag;
                        r_opnd      <= w_b_mag;
                        r_sign_a    <= a[WIDTH-1];
                        r_sign_b    <= b[WIDTH-1];
                        r_is_div    <= op_is_div(op);
                        r_is_signed <= op_is_signed(op);
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= CALC;
                    end
                end
                CALC: begin
                    r_acc   <= w_acc_step;
                    r_shreg <= w_shreg_step;
                    // Wraps back to zero on the last iteration.
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(ITER - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (r_cnt == '0) begin
                        r_acc   <= w_acc_fix;
                        r_shreg <= w_shreg_fix;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    flopenr #(
        .WIDTH (WIDTH)
    ) u_hi_reg (
        .clk   (clk),
        .reset (reset),
        .en    (w_hilo_en),
        .d     (r_acc),
        .q     (hi)
    );

    flopenr #(
        .WIDTH (WIDTH)
    ) u_lo_reg (
        .clk   (clk),
        .reset (reset),
        .en    (w_hilo_en),
        .d     (r_shreg),
        .q     (lo)
    );

    always_comb begin
        busy = r_busy;
        done = r_done;
    end

endmodule
`default_nettype wire

// File: tb/tb_multdiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multdiv
//  Description : Scoreboard bench for multdiv. Issued operations push their
//                expected hi/lo and completion cycle; a negedge monitor pops
//                and compares on every done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multdiv;

    localparam int LAT = 34;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          acc_cyc;
        int          done_cyc;
        string       name;
    } exp_t;

    exp_t sb[$];

    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    multdiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    // Reference model: plain arithmetic on 64-bit values.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: return {32'b0, x} * {32'b0, y};
            2'b01: return 64'(sx * sy);
            2'b10: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: begin
                // Raw divide-by-zero quotient is all ones; it is negated when
                // the dividend is negative, and the remainder keeps a.
                if (y == 0) return {x, (x[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Monitor: scoreboard compare on done, timing and hold checks otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_hi = '0;
            last_lo = '0;
        end else begin
            if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
                e = sb.pop_front();
                total++;
                bad++;
                $display("FAIL %s no_done: actual=none required=done at cycle %0d", e.name, e.done_cyc);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, " hi"}, {32'b0, hi}, {32'b0, e.hi});
                    chk({e.name, " lo"}, {32'b0, lo}, {32'b0, e.lo});
                    chk({e.name, " latency"}, 64'(cyc), 64'(e.done_cyc));
                    chk({e.name, " busy_at_done"}, {63'b0, busy}, 64'd0);
                end
                last_hi = hi;
                last_lo = lo;
            end else begin
                chk("hilo_hold", {hi, lo}, {last_hi, last_lo});
                if (sb.size() > 0 && cyc >= sb[0].acc_cyc && cyc < sb[0].done_cyc)
                    chk({sb[0].name, " busy"}, {63'b0, busy}, 64'd1);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with busy low.
    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL wait_idle: actual busy=%b required busy=0 within 200 cycles", busy);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string nm);
        exp_t        e;
        logic [63:0] m;
        wait_idle();
        m = model(o, x, y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        e.hi       = m[63:32];
        e.lo       = m[31:0];
        e.acc_cyc  = cyc + 1;
        e.done_cyc = cyc + 1 + LAT;
        e.name     = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        // Operands may change freely once accepted.
        op = 2'($urandom);
        a  = $urandom;
        b  = $urandom;
    endtask

    function automatic logic [31:0] pick();
        int k;
        k = $urandom_range(0, 7);
        case (k)
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", {63'b0, busy}, 64'd0);
        chk("reset done", {63'b0, done}, 64'd0);
        chk("reset hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases.
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        issue(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, "mult_neg3x5");
        issue(2'b10, 32'd100,       32'd7,         "divu_100_7");
        issue(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg7_2");
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        issue(2'b10, 32'h0000_1234, 32'h0000_0000, "divu_by0");
        issue(2'b11, 32'h0000_0005, 32'h0000_0000, "div_5_by0");

        // Start pulses while busy must be ignored.
        issue(2'b00, 32'h0001_0003, 32'h0000_0101, "busy_first");
        repeat (5) @(posedge clk);
        #1;
        op = 2'b11; a = 32'h7777_7777; b = 32'h3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        op = 2'b01; a = 32'h1234_5678; b = 32'h9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        // Randomized operations, back to back.
        for (int i = 0; i < 20; i++) begin
            issue(2'($urandom), pick(), pick(), $sformatf("rand%0d", i));
        end

        // Reset 10 cycles into a MULTU: aborts silently and clears hi/lo.
        issue(2'b00, 32'hDEAD_BEEF, 32'h0000_1001, "aborted");
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("abort busy", {63'b0, busy}, 64'd0);
        chk("abort hilo", {hi, lo}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("post_abort busy", {63'b0, busy}, 64'd0);
        chk("post_abort hilo", {hi, lo}, 64'd0);
        issue(2'b00, 32'd3, 32'd4, "multu_3x4");

        begin
            int n = 0;
            while (sb.size() > 0 && n < 200) begin
                @(posedge clk);
                n++;
            end
            if (sb.size() > 0) begin
                total++;
                bad++;
                $display("FAIL drain: actual pending=%0d required=0", sb.size());
            end
        end
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
